// File: rtl/axi_lite_csr_pkg.sv
// Shared definitions for the AXI4-Lite to CSR strobe bridge: response codes,
// the access FSM states and the address alignment helper.
package axi_lite_csr_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_WAIT,
        BRSP,
        RRSP
    } csr_state_e;

    // Number of low address bits that must be zero for a full-word access.
    function automatic int alignBits(input int dataWidth);
        return $clog2(dataWidth / 8);
    endfunction

endpackage

// File: rtl/axi_lite_csr_slot.sv
// One-entry holding register for an AXI channel. Ready is registered and is
// high exactly when the slot is empty; the owner empties it with a one-cycle
// clear pulse once the matching response has been raised.
module axi_lite_csr_slot
    import axi_lite_csr_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    input  logic             i_clear,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);

    logic             r_full;
    logic             r_ready;
    logic [WIDTH-1:0] r_data;

    // Capture on handshake, drop on clear; ready tracks the next empty state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_full  <= 1'b0;
            r_ready <= 1'b0;
            r_data  <= '0;
        end else if (i_valid && r_ready) begin
            r_full  <= 1'b1;
            r_ready <= 1'b0;
            r_data  <= i_data;
        end else if (i_clear) begin
            r_full  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_ready <= !r_full;
        end
    end

    assign o_ready = r_ready;
    assign o_full  = r_full;
    assign o_data  = r_data;

endmodule

// File: rtl/axi_lite_csr_bridge.sv
// AXI4-Lite slave that converts bus accesses into single-cycle CSR read and
// write strobes. AW, W and AR are parked in one-entry slots; a small FSM
// arbitrates fairly between a complete write and a pending read, runs one CSR
// access at a time and holds the response until the master takes it.
module axi_lite_csr_bridge
    import axi_lite_csr_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADD_WIDTH  = 8,
    parameter int          RD_LATENCY = 1,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [31:0]             s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [31:0]             s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [ADD_WIDTH-1:0]    bram_addr,
    output logic                    bram_wr,
    output logic [DATA_WIDTH-1:0]   bram_wr_data,
    output logic [DATA_WIDTH/8-1:0] bram_wr_be,
    output logic                    bram_rd,
    input  logic [DATA_WIDTH-1:0]   bram_rd_data
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int ALIGN      = alignBits(DATA_WIDTH);

    logic                             w_awFull;
    logic [31:0]                      w_awAddr;
    logic                             w_wFull;
    logic [DATA_WIDTH+STRB_WIDTH-1:0] w_wSlot;
    logic [DATA_WIDTH-1:0]            w_wData;
    logic [STRB_WIDTH-1:0]            w_wStrb;
    logic                             w_arFull;
    logic [31:0]                      w_arAddr;
    logic                             w_wrElig;
    logic                             w_rdElig;
    logic                             w_grantWr;
    logic                             w_grantRd;
    logic                             w_wrBad;
    logic                             w_rdBad;

    csr_state_e            r_state;
    logic                  r_lastGrantWr;
    logic [2:0]            r_cnt;
    logic                  r_wrClear;
    logic                  r_arClear;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_rvalid;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [ADD_WIDTH-1:0]  r_bramAddr;
    logic                  r_bramWr;
    logic [DATA_WIDTH-1:0] r_bramWrData;
    logic [STRB_WIDTH-1:0] r_bramWrBe;
    logic                  r_bramRd;

    // An address is rejected when it is outside the window or not word aligned.
    function automatic logic addrBad(input logic [31:0] a);
        return (a[31:ADD_WIDTH] != BASE_ADDR[31:ADD_WIDTH]) || (a[ALIGN-1:0] != '0);
    endfunction

    axi_lite_csr_slot #(.WIDTH(32)) u_awSlot (
        .i_clk   (aclk),
        .i_reset (areset),
        .i_valid (s_axi_awvalid),
        .i_data  (s_axi_awaddr),
        .o_ready (s_axi_awready),
        .i_clear (r_wrClear),
        .o_full  (w_awFull),
        .o_data  (w_awAddr)
    );

    axi_lite_csr_slot #(.WIDTH(DATA_WIDTH + STRB_WIDTH)) u_wSlot (
        .i_clk   (aclk),
        .i_reset (areset),
        .i_valid (s_axi_wvalid),
        .i_data  ({s_axi_wstrb, s_axi_wdata}),
        .o_ready (s_axi_wready),
        .i_clear (r_wrClear),
        .o_full  (w_wFull),
        .o_data  (w_wSlot)
    );

    axi_lite_csr_slot #(.WIDTH(32)) u_arSlot (
        .i_clk   (aclk),
        .i_reset (areset),
        .i_valid (s_axi_arvalid),
        .i_data  (s_axi_araddr),
        .o_ready (s_axi_arready),
        .i_clear (r_arClear),
        .o_full  (w_arFull),
        .o_data  (w_arAddr)
    );

    assign w_wData   = w_wSlot[DATA_WIDTH-1:0];
    assign w_wStrb   = w_wSlot[DATA_WIDTH +: STRB_WIDTH];
    assign w_wrElig  = w_awFull && w_wFull;
    assign w_rdElig  = w_arFull;
    assign w_grantWr = w_wrElig && (!w_rdElig || !r_lastGrantWr);
    assign w_grantRd = w_rdElig && !w_grantWr;
    assign w_wrBad   = addrBad(w_awAddr);
    assign w_rdBad   = addrBad(w_arAddr);

    // Access FSM: grant, issue one CSR strobe, wait for read data, hold response.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state       <= IDLE;
            r_lastGrantWr <= 1'b0;
            r_cnt         <= '0;
            r_wrClear     <= 1'b0;
            r_arClear     <= 1'b0;
            r_bvalid      <= 1'b0;
            r_bresp       <= OKAY;
            r_rvalid      <= 1'b0;
            r_rresp       <= OKAY;
            r_rdata       <= '0;
            r_bramAddr    <= '0;
            r_bramWr      <= 1'b0;
            r_bramWrData  <= '0;
            r_bramWrBe    <= '0;
            r_bramRd      <= 1'b0;
        end else begin
            r_bramWr  <= 1'b0;
            r_bramRd  <= 1'b0;
            r_wrClear <= 1'b0;
            r_arClear <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grantWr) begin
                        r_lastGrantWr <= 1'b1;
                        if (w_wrBad) begin
                            r_bvalid  <= 1'b1;
                            r_bresp   <= SLVERR;
                            r_wrClear <= 1'b1;
                            r_state   <= BRSP;
                        end else begin
                            r_bramAddr   <= w_awAddr[ADD_WIDTH-1:0];
                            r_bramWrData <= w_wData;
                            r_bramWrBe   <= w_wStrb;
                            r_bramWr     <= |w_wStrb;
                            r_state      <= WR;
                        end
                    end else if (w_grantRd) begin
                        r_lastGrantWr <= 1'b0;
                        if (w_rdBad) begin
                            r_rvalid  <= 1'b1;
                            r_rresp   <= SLVERR;
                            r_rdata   <= '0;
                            r_arClear <= 1'b1;
                            r_state   <= RRSP;
                        end else begin
                            r_bramAddr <= w_arAddr[ADD_WIDTH-1:0];
                            r_bramRd   <= 1'b1;
                            r_cnt      <= 3'(RD_LATENCY);
                            r_state    <= RD_WAIT;
                        end
                    end
                end
                WR: begin
                    r_bvalid  <= 1'b1;
                    r_bresp   <= OKAY;
                    r_wrClear <= 1'b1;
                    r_state   <= BRSP;
                end
                RD_WAIT: begin
                    if (r_cnt == 3'd0) begin
                        r_rdata   <= bram_rd_data;
                        r_rvalid  <= 1'b1;
                        r_rresp   <= OKAY;
                        r_arClear <= 1'b1;
                        r_state   <= RRSP;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                BRSP: begin
                    if (s_axi_bready) begin
                        r_bvalid <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                RRSP: begin
                    if (s_axi_rready) begin
                        r_rvalid <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_axi_bvalid = r_bvalid;
    assign s_axi_bresp  = r_bresp;
    assign s_axi_rvalid = r_rvalid;
    assign s_axi_rresp  = r_rresp;
    assign s_axi_rdata  = r_rdata;
    assign bram_addr    = r_bramAddr;
    assign bram_wr      = r_bramWr;
    assign bram_wr_data = r_bramWrData;
    assign bram_wr_be   = r_bramWrBe;
    assign bram_rd      = r_bramRd;

endmodule

// File: tb/tb_axi_lite_csr_bridge.sv
// Directed bench for axi_lite_csr_bridge with a 32-bit CSR memory model whose
// read data appears exactly RD_LATENCY cycles after the read strobe.
module tb_axi_lite_csr_bridge;

    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int LAT = 3;

    logic          aclk = 1'b0;
    logic          areset;
    logic [31:0]   s_axi_awaddr;
    logic          s_axi_awvalid;
    logic          s_axi_awready;
    logic [DW-1:0] s_axi_wdata;
    logic [3:0]    s_axi_wstrb;
    logic          s_axi_wvalid;
    logic          s_axi_wready;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_bvalid;
    logic          s_axi_bready;
    logic [31:0]   s_axi_araddr;
    logic          s_axi_arvalid;
    logic          s_axi_arready;
    logic [DW-1:0] s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rvalid;
    logic          s_axi_rready;
    logic [AW-1:0] bram_addr;
    logic          bram_wr;
    logic [DW-1:0] bram_wr_data;
    logic [3:0]    bram_wr_be;
    logic          bram_rd;
    logic [DW-1:0] bram_rd_data;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    logic [31:0] mem [0:63];
    logic [31:0] pipe [0:LAT] = '{default: 32'hDEAD_BEEF};
    int          wrCount = 0;
    int          rdCount = 0;
    int          bothCount = 0;
    int          lastWrCycle = 0;
    int          lastRdCycle = 0;
    logic [7:0]  lastWrAddr = '0;
    logic [31:0] lastWrData = '0;
    logic [3:0]  lastWrBe = '0;
    bit          order [$];

    axi_lite_csr_bridge #(
        .DATA_WIDTH (DW),
        .ADD_WIDTH  (AW),
        .RD_LATENCY (LAT),
        .BASE_ADDR  (32'h0)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .bram_addr     (bram_addr),
        .bram_wr       (bram_wr),
        .bram_wr_data  (bram_wr_data),
        .bram_wr_be    (bram_wr_be),
        .bram_rd       (bram_rd),
        .bram_rd_data  (bram_rd_data)
    );

    always #5 aclk = ~aclk;

    // Free-running cycle counter used to measure latencies.
    always @(posedge aclk) cycle++;

    assign bram_rd_data = pipe[LAT];

    // CSR memory model and strobe monitor, sampled mid-cycle.
    always @(negedge aclk) begin
        for (int i = LAT; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = 32'hDEAD_BEEF;
        if (!areset) begin
            if (bram_wr && bram_rd) bothCount++;
            if (bram_wr) begin
                wrCount++;
                lastWrCycle = cycle;
                lastWrAddr  = bram_addr;
                lastWrData  = bram_wr_data;
                lastWrBe    = bram_wr_be;
                order.push_back(1'b1);
                for (int b = 0; b < 4; b++)
                    if (bram_wr_be[b]) mem[bram_addr[7:2]][8*b +: 8] = bram_wr_data[8*b +: 8];
            end
            if (bram_rd) begin
                rdCount++;
                lastRdCycle = cycle;
                order.push_back(1'b0);
                pipe[0] = mem[bram_addr[7:2]];
            end
        end
    end

    // Count a comparison and report it when the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Present one write address and hold it until the slot takes it.
    task automatic sendAw(input logic [31:0] a);
        int n;
        @(negedge aclk);
        s_axi_awaddr  = a;
        s_axi_awvalid = 1'b1;
        n = 0;
        while (!s_axi_awready && n < 300) begin @(negedge aclk); n++; end
        if (n >= 300) checkOutput("awTimeout", 1, 0);
        @(negedge aclk);
        s_axi_awvalid = 1'b0;
    endtask

    // Present one write data beat and hold it until the slot takes it.
    task automatic sendW(input logic [31:0] d, input logic [3:0] s);
        int n;
        @(negedge aclk);
        s_axi_wdata  = d;
        s_axi_wstrb  = s;
        s_axi_wvalid = 1'b1;
        n = 0;
        while (!s_axi_wready && n < 300) begin @(negedge aclk); n++; end
        if (n >= 300) checkOutput("wTimeout", 1, 0);
        @(negedge aclk);
        s_axi_wvalid = 1'b0;
    endtask

    // Present one read address and hold it until the slot takes it.
    task automatic sendAr(input logic [31:0] a);
        int n;
        @(negedge aclk);
        s_axi_araddr  = a;
        s_axi_arvalid = 1'b1;
        n = 0;
        while (!s_axi_arready && n < 300) begin @(negedge aclk); n++; end
        if (n >= 300) checkOutput("arTimeout", 1, 0);
        @(negedge aclk);
        s_axi_arvalid = 1'b0;
    endtask

    // Wait for bvalid, check bresp, optionally stall bready, then handshake.
    task automatic applyStimulusB(input string tag, input logic [1:0] expResp, input int hold, output int bCycle);
        int n;
        int rdBefore;
        logic [1:0] firstResp;
        @(negedge aclk);
        n = 0;
        while (!s_axi_bvalid && n < 300) begin @(negedge aclk); n++; end
        bCycle = cycle;
        checkOutput({tag, "_bvalid"}, s_axi_bvalid, 1);
        checkOutput({tag, "_bresp"}, s_axi_bresp, expResp);
        firstResp = s_axi_bresp;
        if (hold > 0) begin
            rdBefore = rdCount;
            repeat (hold) @(negedge aclk);
            checkOutput({tag, "_bvalidHeld"}, s_axi_bvalid, 1);
            checkOutput({tag, "_brespHeld"}, s_axi_bresp, firstResp);
            checkOutput({tag, "_noGrantWhileHeld"}, rdCount, rdBefore);
        end
        s_axi_bready = 1'b1;
        @(negedge aclk);
        s_axi_bready = 1'b0;
        checkOutput({tag, "_bvalidDrop"}, s_axi_bvalid, 0);
    endtask

    // Wait for rvalid, check rresp and rdata, then handshake.
    task automatic applyStimulusR(input string tag, input logic [1:0] expResp, input logic [31:0] expData, output int rCycle);
        int n;
        @(negedge aclk);
        n = 0;
        while (!s_axi_rvalid && n < 300) begin @(negedge aclk); n++; end
        rCycle = cycle;
        checkOutput({tag, "_rvalid"}, s_axi_rvalid, 1);
        checkOutput({tag, "_rresp"}, s_axi_rresp, expResp);
        checkOutput({tag, "_rdata"}, s_axi_rdata, expData);
        s_axi_rready = 1'b1;
        @(negedge aclk);
        s_axi_rready = 1'b0;
        checkOutput({tag, "_rvalidDrop"}, s_axi_rvalid, 0);
    endtask

    initial begin
        int bCyc;
        int rCyc;
        int wr0;
        int rd0;
        int n;
        int sawRvalid;
        logic [3:0] pattern;

        for (int i = 0; i < 64; i++) mem[i] = 32'h0101_0101 * i;
        mem[4] = 32'h1122_3344;
        mem[9] = 32'h1234_5678;

        areset = 1'b1;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;

        // Reset values
        repeat (3) @(negedge aclk);
        checkOutput("rstAwready", s_axi_awready, 0);
        checkOutput("rstWready", s_axi_wready, 0);
        checkOutput("rstArready", s_axi_arready, 0);
        checkOutput("rstBvalid", s_axi_bvalid, 0);
        checkOutput("rstRvalid", s_axi_rvalid, 0);
        checkOutput("rstStrobes", {bram_wr, bram_rd}, 0);
        checkOutput("rstBramAddr", bram_addr, 0);
        checkOutput("rstRdata", s_axi_rdata, 0);
        areset = 1'b0;
        @(negedge aclk);
        checkOutput("relAwready", s_axi_awready, 1);
        checkOutput("relArready", s_axi_arready, 1);

        // Partial-strobe write, AW three cycles ahead of W
        wr0 = wrCount;
        fork
            sendAw(32'h0000_0010);
            begin repeat (3) @(negedge aclk); sendW(32'hA5A5_5A5A, 4'b0110); end
            applyStimulusB("wr10", 2'b00, 0, bCyc);
        join
        checkOutput("wr10_count", wrCount - wr0, 1);
        checkOutput("wr10_addr", lastWrAddr, 8'h10);
        checkOutput("wr10_be", lastWrBe, 4'b0110);
        checkOutput("wr10_data", lastWrData, 32'hA5A5_5A5A);
        checkOutput("wr10_bLatency", bCyc - lastWrCycle, 1);

        // Read back: only bytes 1 and 2 changed
        fork
            sendAr(32'h0000_0010);
            applyStimulusR("rd10", 2'b00, 32'h11A5_5A44, rCyc);
        join

        // Read with RD_LATENCY=3: rvalid four cycles after bram_rd
        fork
            sendAr(32'h0000_0024);
            applyStimulusR("rd24", 2'b00, 32'h1234_5678, rCyc);
        join
        checkOutput("rd24_latency", rCyc - lastRdCycle, LAT + 1);

        // Simultaneous AR/AW/W twice: write, read, write, read
        order.delete();
        fork
            begin sendAw(32'h0000_0030); sendAw(32'h0000_0034); end
            begin sendW(32'hCAFE_0030, 4'hF); sendW(32'hCAFE_0034, 4'hF); end
            begin sendAr(32'h0000_0010); sendAr(32'h0000_0024); end
            begin applyStimulusB("arbW1", 2'b00, 0, bCyc); applyStimulusB("arbW2", 2'b00, 0, bCyc); end
            begin
                applyStimulusR("arbR1", 2'b00, 32'h11A5_5A44, rCyc);
                applyStimulusR("arbR2", 2'b00, 32'h1234_5678, rCyc);
            end
        join
        checkOutput("arbOrderCount", order.size(), 4);
        pattern = '0;
        for (int i = 0; i < order.size() && i < 4; i++) pattern[3-i] = order[i];
        checkOutput("arbOrderSeq", pattern, 4'b1010);
        checkOutput("arbMem30", mem[12], 32'hCAFE_0030);

        // Decode errors and all-zero strobe write
        rd0 = rdCount;
        fork
            sendAr(32'h0000_0102);
            applyStimulusR("errRd", 2'b10, 32'h0, rCyc);
        join
        checkOutput("errRd_noStrobe", rdCount - rd0, 0);
        wr0 = wrCount;
        fork
            sendAw(32'h0000_0003);
            sendW(32'h1111_2222, 4'hF);
            applyStimulusB("errWr", 2'b10, 0, bCyc);
        join
        checkOutput("errWr_noStrobe", wrCount - wr0, 0);
        fork
            sendAw(32'h0000_0038);
            sendW(32'h3333_4444, 4'h0);
            applyStimulusB("zeroStrb", 2'b00, 0, bCyc);
        join
        checkOutput("zeroStrb_noStrobe", wrCount - wr0, 0);

        // Backpressure on B with a read queued behind it
        fork
            sendAw(32'h0000_003C);
            sendW(32'hCAFE_F00D, 4'hF);
            applyStimulusB("hold", 2'b00, 10, bCyc);
            begin repeat (4) @(negedge aclk); sendAr(32'h0000_0024); end
        join
        applyStimulusR("holdRd", 2'b00, 32'h1234_5678, rCyc);
        checkOutput("holdMem3C", mem[15], 32'hCAFE_F00D);

        // Reset while a read waits for CSR data
        rd0 = rdCount;
        sendAr(32'h0000_0024);
        n = 0;
        while (rdCount == rd0 && n < 50) begin @(negedge aclk); n++; end
        checkOutput("rstMid_sawRd", rdCount - rd0, 1);
        areset = 1'b1;
        @(negedge aclk);
        checkOutput("rstMid_awready", s_axi_awready, 0);
        checkOutput("rstMid_wready", s_axi_wready, 0);
        checkOutput("rstMid_arready", s_axi_arready, 0);
        areset = 1'b0;
        @(negedge aclk);
        checkOutput("rstMid_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
        checkOutput("rstMid_noStrobe", {bram_wr, bram_rd}, 0);
        sawRvalid = 0;
        repeat (10) begin
            if (s_axi_rvalid) sawRvalid++;
            @(negedge aclk);
        end
        checkOutput("rstMid_noRvalid", sawRvalid, 0);
        fork
            sendAr(32'h0000_0024);
            applyStimulusR("postRst", 2'b00, 32'h1234_5678, rCyc);
        join

        checkOutput("strobeOverlap", bothCount, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
